// File: rtl/speck_block_fifo.sv
// speck_block_fifo: DEPTH x WIDTH ready/valid buffer with count, full/empty and flush.
// Define SPECK_BUF_BYPASS_EN to add a same-cycle bypass when the buffer is empty.
module speck_block_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         i_in_data,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic [WIDTH-1:0]         o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;

    assign w_full  = r_count == FULL_CNT;
    assign w_empty = r_count == '0;
`ifdef SPECK_BUF_BYPASS_EN
    assign w_bypass = w_empty && i_in_valid;
`else
    assign w_bypass = 1'b0;
`endif
    // a bypassed word taken by the consumer the same cycle never enters storage
    assign w_push = i_in_valid && !w_full && !(w_bypass && i_out_ready);
    assign w_pop  = !w_empty && i_out_ready;

    assign o_in_ready  = !w_full;
    assign o_out_valid = !w_empty || w_bypass;
    assign o_out_data  = w_bypass ? i_in_data : r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= (w_push && !w_pop) ? r_count + CW'(1) :
                       (!w_push && w_pop) ? r_count - CW'(1) : r_count;
        end
    end
endmodule

// File: tb/tb_speck_block_fifo.sv
// tb_speck_block_fifo: table-driven and directed checks of speck_block_fifo (WIDTH 64, DEPTH 4).
module tb_speck_block_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [63:0] d;
        logic        rdy;
        int          cnt;
        logic        ov;
        logic [63:0] od;
        logic        full;
        logic        chk_out;
    } vec_t;

    vec_t        v[16];
    logic [63:0] q[$];

    speck_block_fifo #(.WIDTH(64), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .i_flush(flush), .o_count(count), .o_full(full), .o_empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [63:0] d, input logic rdy);
        flush = fl; in_valid = iv; in_data = d; out_ready = rdy;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // pre-edge expectations: state left by earlier rows, outputs with this row's inputs applied
        v[0]  = '{0, 0, 64'h0,                  0, 0, 0, 64'h0,                  0, 1};
        v[1]  = '{0, 1, 64'h1111111111111111,   0, 0, 0, 64'h0,                  0, 0};
        v[2]  = '{0, 1, 64'h2222222222222222,   0, 1, 1, 64'h1111111111111111,   0, 1};
        v[3]  = '{0, 1, 64'h3333333333333333,   0, 2, 1, 64'h1111111111111111,   0, 1};
        v[4]  = '{0, 1, 64'h4444444444444444,   0, 3, 1, 64'h1111111111111111,   0, 1};
        v[5]  = '{0, 1, 64'h5555555555555555,   0, 4, 1, 64'h1111111111111111,   1, 1};
        v[6]  = '{0, 0, 64'h0,                  0, 4, 1, 64'h1111111111111111,   1, 1};
        v[7]  = '{0, 0, 64'h0,                  1, 4, 1, 64'h1111111111111111,   1, 1};
        v[8]  = '{0, 0, 64'h0,                  1, 3, 1, 64'h2222222222222222,   0, 1};
        v[9]  = '{0, 0, 64'h0,                  1, 2, 1, 64'h3333333333333333,   0, 1};
        v[10] = '{0, 0, 64'h0,                  1, 1, 1, 64'h4444444444444444,   0, 1};
        v[11] = '{0, 0, 64'h0,                  0, 0, 0, 64'h0,                  0, 1};
        v[12] = '{0, 1, 64'h0101010101010101,   0, 0, 0, 64'h0,                  0, 0};
        v[13] = '{0, 1, 64'h0202020202020202,   0, 1, 1, 64'h0101010101010101,   0, 1};
        v[14] = '{0, 1, 64'h0303030303030303,   1, 2, 1, 64'h0101010101010101,   0, 1};
        v[15] = '{0, 1, 64'h0404040404040404,   1, 2, 1, 64'h0202020202020202,   0, 1};

        #12;
        chk("reset count", 64'(count), 64'd0);
        chk("reset empty", 64'(empty), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", out_data, 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            drive(v[i].fl, v[i].iv, v[i].d, v[i].rdy);
            #1;
            chk($sformatf("row%0d count", i), 64'(count), 64'(v[i].cnt));
            chk($sformatf("row%0d full", i), 64'(full), 64'(v[i].full));
            chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(!v[i].full));
            chk($sformatf("row%0d empty", i), 64'(empty), 64'(v[i].cnt == 0));
            if (v[i].chk_out) begin
                chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(v[i].ov));
                if (v[i].ov) chk($sformatf("row%0d out_data", i), out_data, v[i].od);
            end
            step();
        end

        q = '{64'h0303030303030303, 64'h0404040404040404};
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 64'hA000_0000_0000_0000 + 64'(k), 1);
            #1;
            chk($sformatf("wrap%0d count", k), 64'(count), 64'd2);
            chk($sformatf("wrap%0d out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("wrap%0d out_data", k), out_data, q[0]);
            step();
            void'(q.pop_front());
            q.push_back(in_data);
        end

        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 64'hB000_0000_0000_0000 + 64'(k), 0);
            step();
            q.push_back(in_data);
        end
        chk("fill full", 64'(full), 64'd1);
        chk("fill in_ready", 64'(in_ready), 64'd0);
        chk("fill count", 64'(count), 64'd4);
        drive(0, 1, 64'hDEAD_0000_0000_0001, 1);
        #1;
        chk("full pop head", out_data, q[0]);
        step();
        void'(q.pop_front());
        drive(0, 0, 64'h0, 0);
        #1;
        chk("full pop count", 64'(count), 64'd3);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 64'h0, 1);
            #1;
            chk($sformatf("drain%0d out_data", k), out_data, q[0]);
            step();
            void'(q.pop_front());
        end
        drive(0, 0, 64'h0, 0);
        #1;
        chk("drain empty", 64'(empty), 64'd1);

        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 64'hC000_0000_0000_0000 + 64'(k), 0);
            step();
        end
        drive(1, 1, 64'hEEEE_EEEE_EEEE_EEEE, 1);
        #1;
        chk("preflush count", 64'(count), 64'd3);
        step();
        drive(0, 0, 64'h0, 0);
        #1;
        chk("flush count", 64'(count), 64'd0);
        chk("flush empty", 64'(empty), 64'd1);
        chk("flush out_valid", 64'(out_valid), 64'd0);

        drive(0, 1, 64'hDEADBEEF_CAFEF00D, 1);
        #1;
`ifdef SPECK_BUF_BYPASS_EN
        chk("bypass out_valid", 64'(out_valid), 64'd1);
        chk("bypass out_data", out_data, 64'hDEADBEEF_CAFEF00D);
        step();
        drive(0, 0, 64'h0, 0);
        #1;
        chk("bypass count", 64'(count), 64'd0);
`else
        chk("nobypass out_valid", 64'(out_valid), 64'd0);
        step();
        drive(0, 0, 64'h0, 0);
        #1;
        chk("nobypass later valid", 64'(out_valid), 64'd1);
        chk("nobypass later data", out_data, 64'hDEADBEEF_CAFEF00D);
        chk("nobypass count", 64'(count), 64'd1);
        drive(0, 0, 64'h0, 1);
        step();
        drive(0, 0, 64'h0, 0);
        #1;
        chk("nobypass drained", 64'(empty), 64'd1);
`endif

        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 64'hF000_0000_0000_0000 + 64'(k), 0);
            step();
        end
        drive(0, 0, 64'h0, 0);
        #1;
        chk("prereset count", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset count", 64'(count), 64'd0);
        chk("midreset empty", 64'(empty), 64'd1);
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset out_data", out_data, 64'd0);
        chk("midreset in_ready", 64'(in_ready), 64'd1);
        #3;
        rst_n = 1'b1;
        step();
        chk("postreset empty", 64'(empty), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
